// File: rtl/cache_pkg.sv
// Shared geometry, address-field helpers and FSM state type for the
// direct-mapped cache miss-handling path (4 lines x 4 words).
package cache_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TAG_W          = 2;
  localparam int LINE_W         = 2;
  localparam int OFF_W          = 2;
  localparam int WORDS_PER_LINE = 1 << OFF_W;
  // Address bits above the tag field; they pass through unchanged.
  localparam int HI_W           = ADDR_W - TAG_W - LINE_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [LINE_W-1:0] addr_line(input logic [ADDR_W-1:0] a);
    return a[OFF_W+LINE_W-1:OFF_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[OFF_W+LINE_W+TAG_W-1:OFF_W+LINE_W];
  endfunction

  function automatic logic [HI_W-1:0] addr_hi(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ADDR_W-HI_W];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Signal bundle between the refill controller (master) and the cache array,
// victim read port and word-wide RAM port (slave).
interface cache_refill_ctrl_if;
  import cache_pkg::*;

  // Handshakes: a miss is accepted on a cycle with miss_valid & miss_ready.
  // A RAM word moves on a cycle with ram_req & ram_ack; ram_req, ram_we,
  // ram_addr and ram_wdata stay stable until that cycle, and ram_ack seen
  // while ram_req is low has no effect.
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [OFF_W-1:0]  victim_rd_offset;
  logic [DATA_W-1:0] victim_rd_data;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;
  logic              fill_we;
  logic [LINE_W-1:0] fill_line;
  logic [OFF_W-1:0]  fill_offset;
  logic [DATA_W-1:0] fill_data;
  logic              crit_valid;
  logic              fill_done;
  logic [TAG_W-1:0]  fill_tag;
  logic              cpu_stall;

  modport master (
    input  miss_valid, miss_addr, victim_dirty, victim_tag, victim_rd_data,
           ram_ack, ram_rdata,
    output miss_ready, victim_rd_offset, ram_req, ram_we, ram_addr, ram_wdata,
           fill_we, fill_line, fill_offset, fill_data, crit_valid, fill_done,
           fill_tag, cpu_stall
  );

  modport slave (
    output miss_valid, miss_addr, victim_dirty, victim_tag, victim_rd_data,
           ram_ack, ram_rdata,
    input  miss_ready, victim_rd_offset, ram_req, ram_we, ram_addr, ram_wdata,
           fill_we, fill_line, fill_offset, fill_data, crit_valid, fill_done,
           fill_tag, cpu_stall
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Read-miss handler: optional write-back of the dirty victim line, then a
// critical-word-first refill of the missing line, stalling the CPU throughout.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  cache_refill_ctrl_if.master bus,
  output state_t              dbg_state
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [TAG_W-1:0]  vtag_q;
  logic [OFF_W-1:0]  cnt;    // words transferred in the current phase
  logic [OFF_W-1:0]  off;    // word offset currently on the RAM port
  logic              req_q;
  logic              we_q;
  logic              ready_q;
  logic              stall_q;
  logic              done_q;
  logic              beat;
  logic              last;
  logic [ADDR_W-1:0] ram_addr_c;

  assign beat = req_q & bus.ram_ack;
  assign last = &cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      vtag_q  <= '0;
      cnt     <= '0;
      off     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.miss_valid) begin
            addr_q  <= bus.miss_addr;
            vtag_q  <= bus.victim_tag;
            cnt     <= '0;
            req_q   <= 1'b1;
            ready_q <= 1'b0;
            stall_q <= 1'b1;
            if (bus.victim_dirty) begin
              state <= WB;
              we_q  <= 1'b1;
              off   <= '0;
            end else begin
              state <= FILL;
              we_q  <= 1'b0;
              off   <= addr_off(bus.miss_addr);
            end
          end
        end
        WB: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            off <= off + 1'b1;
            // The fill restarts at the requested word, not at offset 0.
            if (last) begin
              state <= FILL;
              we_q  <= 1'b0;
              off   <= addr_off(addr_q);
            end
          end
        end
        FILL: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            off <= off + 1'b1;
            if (last) begin
              state  <= DONE;
              req_q  <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          stall_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back targets the victim's own address: same line, victim tag.
  always_comb begin
    ram_addr_c = '0;
    case (state)
      WB:      ram_addr_c = {addr_hi(addr_q), vtag_q, addr_line(addr_q), off};
      FILL:    ram_addr_c = {addr_q[ADDR_W-1:OFF_W], off};
      default: ram_addr_c = '0;
    endcase
  end

  assign bus.miss_ready       = ready_q;
  assign bus.cpu_stall        = stall_q;
  assign bus.ram_req          = req_q;
  assign bus.ram_we           = we_q;
  assign bus.ram_addr         = ram_addr_c;
  assign bus.victim_rd_offset = (state == WB) ? off : '0;
  assign bus.ram_wdata        = (state == WB) ? bus.victim_rd_data : '0;
  assign bus.fill_we          = (state == FILL) & beat;
  assign bus.fill_line        = addr_line(addr_q);
  assign bus.fill_offset      = off;
  assign bus.fill_data        = bus.ram_rdata;
  assign bus.crit_valid       = (state == FILL) & beat & (cnt == '0);
  assign bus.fill_done        = done_q;
  assign bus.fill_tag         = addr_tag(addr_q);
  assign dbg_state            = state;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: a RAM responder with programmable
// wait states and a per-miss transaction model built from the address rules.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     total = 0;
  int     bad = 0;
  int     wait_min = 0;
  int     wait_max = 0;
  logic [31:0] rseed;
  logic [31:0] vseed = 32'h0;

  always #5 clk = ~clk;

  cache_refill_ctrl_if bus();

  cache_refill_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ rseed;
  endfunction

  function automatic logic [31:0] victim_word(input logic [1:0] k);
    return vseed + ({30'b0, k} * 32'h01010101);
  endfunction

  assign bus.victim_rd_data = victim_word(bus.victim_rd_offset);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM responder: drives ack/rdata just after each rising edge.
  initial begin
    int wl;
    bit armed;
    wl = 0;
    armed = 1'b0;
    bus.ram_ack = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ram_ack = 1'b0;
      bus.ram_rdata = $urandom();
      if (bus.ram_req && !reset) begin
        if (!armed) begin
          wl = $urandom_range(wait_max, wait_min);
          armed = 1'b1;
        end
        if (wl == 0) begin
          bus.ram_ack = 1'b1;
          bus.ram_rdata = ram_word(bus.ram_addr);
          armed = 1'b0;
        end else begin
          wl--;
        end
      end else begin
        armed = 1'b0;
        if (!reset && $urandom_range(0, 3) == 0) bus.ram_ack = 1'b1;
      end
    end
  end

  // w >= 0: fixed wait states per word (timing checked); w < 0: random 0..2.
  task automatic run_miss(input logic [31:0] addr, input bit dirty, input logic [1:0] vtag,
                          input int abort_at, input bit spurious, input int w);
    logic [64:0] exp_q[$];
    logic [33:0] fill_q[$];
    logic [64:0] e;
    logic [33:0] f;
    logic [31:0] a;
    logic [1:0]  o;
    logic [31:0] pend_addr;
    int cyc, fills, stall_bad, hold_bad, exp_done, exp_crit, crit_cyc;
    bit done, pend;

    if (w >= 0) begin
      wait_min = w;
      wait_max = w;
    end else begin
      wait_min = 0;
      wait_max = 2;
    end
    vseed = $urandom();
    if (dirty)
      for (int k = 0; k < 4; k++)
        exp_q.push_back({1'b1, addr[31:6], vtag, addr[3:2], 2'(k), victim_word(2'(k))});
    for (int k = 0; k < 4; k++) begin
      o = 2'(int'(addr[1:0]) + k);
      a = {addr[31:2], o};
      exp_q.push_back({1'b0, a, ram_word(a)});
      fill_q.push_back({o, ram_word(a)});
    end
    exp_crit = (dirty ? 4 : 0) * (w + 1) + (w + 1);
    exp_done = (dirty ? 8 : 4) * (w + 1) + 1;

    @(negedge clk);
    chk("miss_ready_idle", bus.miss_ready, 1);
    bus.miss_valid = 1'b1;
    bus.miss_addr = addr;
    bus.victim_dirty = dirty;
    bus.victim_tag = vtag;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    bus.victim_dirty = 1'($urandom());
    bus.victim_tag = 2'($urandom());
    cyc = 1; fills = 0; stall_bad = 0; hold_bad = 0; crit_cyc = 0;
    done = 1'b0; pend = 1'b0; pend_addr = '0;

    while (!done && cyc < 400) begin
      if (spurious && cyc == 2) begin
        bus.miss_valid = 1'b1;
        bus.miss_addr = addr ^ 32'h3C;
        chk("miss_ready_busy", bus.miss_ready, 0);
      end
      if (cyc == 4) bus.miss_valid = 1'b0;
      if (!bus.cpu_stall || bus.miss_ready) stall_bad++;
      if (pend && (!bus.ram_req || bus.ram_addr !== pend_addr)) hold_bad++;
      pend = bus.ram_req && !bus.ram_ack;
      pend_addr = bus.ram_addr;
      if (bus.ram_req && bus.ram_ack) begin
        if (exp_q.size() == 0) chk("ram_extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ram_we", bus.ram_we, e[64]);
          chk("ram_addr", bus.ram_addr, e[63:32]);
          if (e[64]) chk("ram_wdata", bus.ram_wdata, e[31:0]);
        end
      end
      if (bus.fill_we) begin
        fills++;
        chk("fill_we_on_read_beat", bus.ram_req && bus.ram_ack && !bus.ram_we, 1);
        chk("crit_valid", bus.crit_valid, fills == 1);
        if (fills == 1) crit_cyc = cyc;
        chk("fill_line", bus.fill_line, addr[3:2]);
        if (fill_q.size() == 0) chk("fill_extra_word", 1, 0);
        else begin
          f = fill_q.pop_front();
          chk("fill_offset", bus.fill_offset, f[33:32]);
          chk("fill_data", bus.fill_data, f[31:0]);
        end
      end else if (bus.crit_valid) begin
        chk("crit_without_fill", 1, 0);
      end
      if (bus.fill_done) begin
        done = 1'b1;
        chk("fill_tag", bus.fill_tag, addr[5:4]);
        if (w >= 0) begin
          chk("done_cycle", cyc, exp_done);
          chk("crit_cycle", crit_cyc, exp_crit);
        end
      end
      if (abort_at > 0 && fills == abort_at) begin
        reset = 1'b1;
        bus.miss_valid = 1'b0;
        @(negedge clk);
        chk("abort_ram_req", bus.ram_req, 0);
        chk("abort_fill_done", bus.fill_done, 0);
        chk("abort_miss_ready", bus.miss_ready, 1);
        chk("abort_stall", bus.cpu_stall, 0);
        chk("abort_state", dbg_state, IDLE);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("abort_quiet", {bus.fill_done, bus.fill_we, bus.ram_req}, 3'b000);
        end
        return;
      end
      @(negedge clk);
      cyc++;
    end
    bus.miss_valid = 1'b0;
    chk("fill_done_seen", done, 1);
    chk("fill_done_pulse", bus.fill_done, 0);
    chk("ready_after_done", bus.miss_ready, 1);
    chk("stall_after_done", bus.cpu_stall, 0);
    chk("stall_continuous", stall_bad, 0);
    chk("req_held_until_ack", hold_bad, 0);
    chk("ram_words_left", exp_q.size(), 0);
    chk("fill_words_left", fill_q.size(), 0);
  endtask

  initial begin
    rseed = $urandom();
    bus.miss_valid = 1'b0;
    bus.miss_addr = '0;
    bus.victim_dirty = 1'b0;
    bus.victim_tag = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_miss_ready", bus.miss_ready, 1);
    chk("rst_ram_req", bus.ram_req, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_fill_we", bus.fill_we, 0);
    chk("rst_crit", bus.crit_valid, 0);
    chk("rst_fill_done", bus.fill_done, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    run_miss(32'h10, 1'b0, 2'b00, 0, 1'b0, 0);
    run_miss(32'h2E, 1'b0, 2'b01, 0, 1'b0, 0);
    run_miss(32'h04, 1'b1, 2'b11, 0, 1'b0, 0);
    run_miss(32'h10, 1'b0, 2'b00, 0, 1'b0, 3);
    run_miss(32'h27, 1'b1, 2'b10, 0, 1'b0, 3);
    run_miss(32'h08, 1'b0, 2'b00, 2, 1'b0, 0);
    run_miss(32'h09, 1'b0, 2'b00, 0, 1'b0, 0);
    run_miss(32'h31, 1'b0, 2'b00, 0, 1'b1, 0);
    for (int i = 0; i < 12; i++)
      run_miss($urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
